mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RISC-V pipeline. It sits between the EX/MEM register and the MEM/WB register.
- Converts load/store control from EX/MEM into a registered req/ack data-memory bus transaction with byte enables, then sign- or zero-extends load data.
- Drives the MEM/WB register inputs and stalls the upstream pipeline while a bus access is outstanding.
- Traps misaligned accesses and bus timeouts.

Parameters:
- P_TIMEOUT, 16, max cycles in BUSY waiting for i_dmem_ack before abort (range 2..255).

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_MemRead  in  1  load instruction in EX/MEM
- i_MemWrite  in  1  store instruction in EX/MEM
- i_funct3  in  3  load/store size and sign
- i_ALU_result  in  32  effective address, or ALU result for non-memory instructions
- i_Write_Data  in  32  store data (rs2)
- i_RegWrite  in  1  writeback enable from EX/MEM
- i_MemToReg  in  1  writeback select from EX/MEM
- i_Rd  in  5  destination register
- o_dmem_req  out  1  bus request, registered
- o_dmem_we  out  1  1 = write, registered
- o_dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}), registered
- o_dmem_be  out  4  byte enables, registered
- o_dmem_wdata  out  32  lane-replicated store data, registered
- i_dmem_ack  in  1  bus completion, sampled only while o_dmem_req=1
- i_dmem_rdata  in  32  read word, valid with i_dmem_ack
- o_RegWrite  out  1  to MEM/WB
- o_MemToReg  out  1  to MEM/WB
- o_Read_Data  out  32  extended load data, to MEM/WB
- o_ALU_result  out  32  pass-through, to MEM/WB
- o_Rd  out  5  pass-through, to MEM/WB
- o_stall  out  1  freeze PC/IF/ID/EX/MEM registers
- o_misaligned  out  1  one-cycle exception flag
- o_bus_err  out  1  one-cycle timeout flag

Behaviour:
- Reset value of all registered outputs and state is 0/IDLE. o_dmem_req drops immediately on reset, including mid-transaction; no ack is expected afterwards.
- mem_op = i_MemRead | i_MemWrite. If both are set, the load takes priority.
- Misalignment rules:
  - halfword access with addr[0]=1 is misaligned;
  - word access with addr[1:0]!=0 is misaligned;
  - byte accesses are never misaligned.
- funct3 decode:
  - 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
  - Other codes are treated as W.
  - BU/HU on a store are treated as SB/SH.
- Store enables and data:
  - SB: be = 4'b0001<<addr[1:0], wdata = {4{data[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{data[15:0]}}.
  - SW: be = 1111.
  - Loads: be = 1111, and the lane is selected on return.
- FSM states: IDLE, BUSY.
- IDLE:
  - Aligned mem_op: register the bus fields, set o_dmem_req, clear the timeout counter, go to BUSY. o_stall=1 this cycle.
  - Misaligned mem_op: no bus access, o_misaligned=1, o_stall=0, o_RegWrite forced to 0.
  - Non-memory op: pass-through, o_stall=0.
- BUSY:
  - Counter increments each cycle.
  - i_dmem_ack=1: o_stall=0; o_Read_Data = extended i_dmem_rdata (combinational, same cycle); drop o_dmem_req; go to IDLE.
  - No ack and counter==P_TIMEOUT-1: drop o_dmem_req; o_bus_err=1; o_stall=0; o_RegWrite forced to 0; o_Read_Data=0; go to IDLE.
  - Ack and timeout in the same cycle: ack wins, no error.
  - Otherwise: o_stall=1.
- While o_stall=1, o_RegWrite is forced to 0, so MEM/WB captures a bubble each stall cycle.
- Otherwise o_RegWrite, o_MemToReg, o_ALU_result and o_Rd follow the inputs combinationally.
- Load extension: the selected byte/half lane (by addr[1:0]) is sign-extended for B/H and zero-extended for BU/HU.
- o_Read_Data=0 for non-load cycles.
- Latency:
  - an aligned memory op occupies at least 2 cycles (the IDLE request cycle plus at least one BUSY cycle);
  - non-memory ops occupy 1 cycle;
  - back-to-back memory ops re-enter BUSY on the cycle after ack.
- Bus fields stay stable from req rise until ack or abort.

Test Plan:
- ALU op, i_RegWrite=1, i_ALU_result=0x1234, Rd=5, no mem_op -> same-cycle o_RegWrite=1, o_ALU_result=0x1234, o_Rd=5, o_stall=0, o_dmem_req never rises.
- LB at addr 0x103 with ack after 2 BUSY cycles, rdata=0x80FF_1122 -> be=1111, addr=0x100; o_stall=1 for 2 cycles; ack cycle o_Read_Data=0xFFFF_FF80, o_RegWrite=1.
- SH at addr 0x202, data=0xABCD_5678 -> be=1100, wdata=0x5678_5678, we=1; stall released on ack.
- LW at addr 0x101 -> o_misaligned=1 for one cycle, o_RegWrite=0, no req, o_stall=0.
- LHU at 0x40 with ack never returned -> o_bus_err=1 at BUSY cycle 16, req dropped, o_RegWrite=0, state back to IDLE; then ack asserted on the exact timeout cycle -> no error, o_Read_Data is rdata[15:0] zero-extended.
- i_reset asserted in BUSY mid-wait -> o_dmem_req=0 and o_stall=0 immediately; after release, next LW proceeds normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: RISC-V MEM stage driving a registered req/ack data bus with byte enables,
// load lane extension, upstream stall, and misalignment / bus-timeout traps.
module mem_access_stage #(
    parameter int P_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_ALU_result,
    input  logic [31:0] i_Write_Data,
    input  logic        i_RegWrite,
    input  logic        i_MemToReg,
    input  logic [4:0]  i_Rd,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_RegWrite,
    output logic        o_MemToReg,
    output logic [31:0] o_Read_Data,
    output logic [31:0] o_ALU_result,
    output logic [4:0]  o_Rd,
    output logic        o_stall,
    output logic        o_misaligned,
    output logic        o_bus_err
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nxt;
    logic [7:0] cnt;
    logic [2:0] f3_q;
    logic [1:0] off_q;
    logic mem_op, is_b, is_h, misaligned, start, ack, timeout, reg_write;
    logic [3:0] be_nxt;
    logic [31:0] wdata_nxt;

    // Codes other than B/H (including 011/110/111) fall through to word size.
    assign mem_op     = i_MemRead | i_MemWrite;
    assign is_b       = i_funct3[1:0] == 2'b00;
    assign is_h       = i_funct3[1:0] == 2'b01;
    assign misaligned = is_h ? i_ALU_result[0] : !is_b && (i_ALU_result[1:0] != 2'b00);
    assign be_nxt     = i_MemRead ? 4'b1111 :
                        is_b ? 4'b0001 << i_ALU_result[1:0] :
                        is_h ? (i_ALU_result[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_nxt  = is_b ? {4{i_Write_Data[7:0]}} : is_h ? {2{i_Write_Data[15:0]}} : i_Write_Data;
    assign start      = state == IDLE && mem_op && !misaligned;
    assign ack        = state == BUSY && o_dmem_req && i_dmem_ack;
    assign timeout    = state == BUSY && !ack && cnt == 8'(P_TIMEOUT - 1);

    assign o_MemToReg   = i_MemToReg;
    assign o_ALU_result = i_ALU_result;
    assign o_Rd         = i_Rd;

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        return f3[1:0] == 2'b00 ? {{24{b[7] & !f3[2]}}, b} :
               f3[1:0] == 2'b01 ? {{16{h[15] & !f3[2]}}, h} : d;
    endfunction

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else state <= state_nxt;
    end

    // Size and lane are captured with the request so extension does not depend on held inputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt          <= '0;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_be    <= '0;
            o_dmem_wdata <= '0;
            f3_q         <= '0;
            off_q        <= '0;
        end else if (start) begin
            cnt          <= '0;
            o_dmem_req   <= 1'b1;
            o_dmem_we    <= !i_MemRead;
            o_dmem_addr  <= {i_ALU_result[31:2], 2'b00};
            o_dmem_be    <= be_nxt;
            o_dmem_wdata <= wdata_nxt;
            f3_q         <= i_funct3;
            off_q        <= i_ALU_result[1:0];
        end else if (state == BUSY) begin
            cnt <= cnt + 8'd1;
            if (ack || timeout) o_dmem_req <= 1'b0;
        end
    end

    always_comb begin
        state_nxt    = state;
        o_stall      = 1'b0;
        o_misaligned = 1'b0;
        o_bus_err    = 1'b0;
        o_Read_Data  = '0;
        reg_write    = i_RegWrite;
        if (state == IDLE) begin
            if (mem_op && misaligned) begin
                o_misaligned = 1'b1;
                reg_write    = 1'b0;
            end else if (mem_op) begin
                o_stall   = 1'b1;
                state_nxt = BUSY;
            end
        end else if (ack) begin
            state_nxt   = IDLE;
            o_Read_Data = o_dmem_we ? '0 : extend(f3_q, off_q, i_dmem_rdata);
        end else if (timeout) begin
            state_nxt = IDLE;
            o_bus_err = 1'b1;
            reg_write = 1'b0;
        end else begin
            o_stall = 1'b1;
        end
        if (i_reset) o_stall = 1'b0;
        o_RegWrite = reg_write & !o_stall;
    end
endmodule
